// File: rtl/nv_ram_dp_fifo_pkg.sv
// rtl/nv_ram_dp_fifo_pkg.sv - shared constants and types for the dual-port RAM FIFO controller
package nv_ram_dp_fifo_pkg;

  localparam int DEPTH_DEFAULT = 256;
  localparam int AW_DEFAULT    = 8;
  localparam int DW_DEFAULT    = 64;
  localparam int OBUF_DEPTH    = 2;
  localparam int RAM_RD_LAT    = 1;

  typedef logic [AW_DEFAULT-1:0] ptr_t;
  typedef logic [AW_DEFAULT:0]   cnt_t;
  typedef logic [1:0]            obuf_cnt_t;

endpackage

// File: rtl/nv_ram_dp_fifo_obuf.sv
// rtl/nv_ram_dp_fifo_obuf.sv - 2-entry in-order output buffer that catches RAM read data
module nv_ram_dp_fifo_obuf
  import nv_ram_dp_fifo_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cap,
  input  logic [DW-1:0] cap_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output obuf_cnt_t     cnt
);

  logic [DW-1:0] ent0;
  logic [DW-1:0] ent1;

  // ent0 is always the head; capture with cnt==2 is excluded by the read credit rule
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= '0;
    end else begin
      case ({cap, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= cap_data;
          else             ent1 <= cap_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= cap_data;
          end else begin
            ent0 <= ent1;
            ent1 <= cap_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = ent0;

endmodule

// File: rtl/nv_ram_dp_fifo_ctrl.sv
// rtl/nv_ram_dp_fifo_ctrl.sv - valid/ready FIFO controller for a 1-cycle-latency dual-port RAM
// Optional occupancy output fifo_count enabled by NV_RAM_DP_FIFO_COUNT_EN.
module nv_ram_dp_fifo_ctrl
  import nv_ram_dp_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic          ram_cenb,
  output logic [AW-1:0] ram_ab,
  output logic [DW-1:0] ram_db,
  output logic          ram_cena,
  output logic [AW-1:0] ram_aa,
  input  logic [DW-1:0] ram_qa
`ifdef NV_RAM_DP_FIFO_COUNT_EN
  ,
  output logic [AW+1:0] fifo_count
`endif
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   ram_cnt;
  logic [AW:0]   ram_cnt_nxt;
  logic          inflight;
  logic          wr_prdy_q;
  logic          push;
  logic          pop;
  logic          issue;
  logic [2:0]    credit;
  obuf_cnt_t     obuf_cnt;

  // Gating with reset keeps the write strobe quiet while reset is held
  assign wr_prdy = wr_prdy_q & nvdla_core_rstn;
  assign push    = wr_pvld & wr_prdy;
  assign pop     = rd_pvld & rd_prdy;

  // Only prefetch when the entry it returns is guaranteed a slot in the output buffer
  assign credit      = {1'b0, obuf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue       = (ram_cnt != '0) && (credit < 3'(OBUF_DEPTH));
  assign ram_cnt_nxt = ram_cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, issue};

  assign ram_cenb = ~push;
  assign ram_ab   = wr_ptr;
  assign ram_db   = wr_pd;
  assign ram_cena = ~issue;
  assign ram_aa   = rd_ptr;
  assign rd_pvld  = (obuf_cnt != '0);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      inflight  <= 1'b0;
      wr_prdy_q <= 1'b1;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_ONE;
      if (issue) rd_ptr <= rd_ptr + PTR_ONE;
      ram_cnt   <= ram_cnt_nxt;
      inflight  <= issue;
      wr_prdy_q <= (ram_cnt_nxt < FULL_CNT);
    end
  end

  nv_ram_dp_fifo_obuf #(.DW(DW)) u_obuf (
    .clk      (nvdla_core_clk),
    .rst_n    (nvdla_core_rstn),
    .cap      (inflight),
    .cap_data (ram_qa),
    .pop      (pop),
    .head     (rd_pd),
    .cnt      (obuf_cnt)
  );

`ifdef NV_RAM_DP_FIFO_COUNT_EN
  assign fifo_count = {1'b0, ram_cnt} + {{(AW+1){1'b0}}, inflight} + {{AW{1'b0}}, obuf_cnt};
`endif

endmodule

// File: tb/tb_nv_ram_dp_fifo_ctrl.sv
// tb/tb_nv_ram_dp_fifo_ctrl.sv - randomized bench with per-item timeline model for nv_ram_dp_fifo_ctrl
module tb_nv_ram_dp_fifo_ctrl;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int DW    = 64;
  localparam int M     = 1024;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wr_pvld = 1'b0;
  logic [DW-1:0] wr_pd = '0;
  logic          rd_prdy = 1'b0;
  logic [DW-1:0] ram_qa = '0;
  logic          wr_prdy, rd_pvld, ram_cenb, ram_cena;
  logic [AW-1:0] ram_ab, ram_aa;
  logic [DW-1:0] rd_pd, ram_db;
`ifdef NV_RAM_DP_FIFO_COUNT_EN
  logic [AW+1:0] fifo_count;
`endif

  always #5 clk = ~clk;

  nv_ram_dp_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .wr_pvld         (wr_pvld),
    .wr_prdy         (wr_prdy),
    .wr_pd           (wr_pd),
    .rd_pvld         (rd_pvld),
    .rd_prdy         (rd_prdy),
    .rd_pd           (rd_pd),
    .ram_cenb        (ram_cenb),
    .ram_ab          (ram_ab),
    .ram_db          (ram_db),
    .ram_cena        (ram_cena),
    .ram_aa          (ram_aa),
    .ram_qa          (ram_qa)
`ifdef NV_RAM_DP_FIFO_COUNT_EN
    ,
    .fifo_count      (fifo_count)
`endif
  );

  // The RAM the parent would instantiate
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!ram_cenb) mem[ram_ab] <= ram_db;
    if (!ram_cena) ram_qa <= mem[ram_aa];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: every item has an acceptance cycle and an issue cycle; it lives at RAM
  // address (sequence number mod DEPTH) and is readable two cycles after issue.
  logic [DW-1:0] dat [M];
  int acc_t [M];
  int iss_t [M];
  int n_acc = 0, n_iss = 0, n_pop = 0, t = 0;
  int dut_iss = 0, dut_pop = 0;
  bit e_prdy, e_vld, e_pop, e_push, e_iss;

  always @(negedge clk) begin
    if (!rstn) begin
      check("rst_rd_pvld", rd_pvld, 0);
      check("rst_cena", ram_cena, 1);
      check("rst_cenb", ram_cenb, 1);
      check("rst_rd_pd", rd_pd, 0);
      n_acc = 0; n_iss = 0; n_pop = 0;
      dut_iss = 0; dut_pop = 0;
    end else begin
      e_prdy = (n_acc - n_iss) < DEPTH;
      e_vld  = (n_pop < n_iss) && (iss_t[n_pop % M] + 2 <= t);
      e_pop  = e_vld && rd_prdy;
      e_push = wr_pvld && e_prdy;
      e_iss  = (n_iss < n_acc) && (acc_t[n_iss % M] < t) && (n_iss - n_pop - int'(e_pop) < 2);

      check("wr_prdy", wr_prdy, e_prdy);
      check("rd_pvld", rd_pvld, e_vld);
      if (e_vld) check("rd_pd", rd_pd, dat[n_pop % M]);
      check("ram_cenb", ram_cenb, !e_push);
      if (e_push) begin
        check("ram_ab", ram_ab, n_acc % DEPTH);
        check("ram_db", ram_db, wr_pd);
      end
      check("ram_cena", ram_cena, !e_iss);
      if (e_iss) check("ram_aa", ram_aa, n_iss % DEPTH);
      check("port_clash", !ram_cena && !ram_cenb && (ram_aa == ram_ab), 0);
`ifdef NV_RAM_DP_FIFO_COUNT_EN
      check("fifo_count", fifo_count, n_acc - n_pop);
`endif
      if (!ram_cena) dut_iss++;
      if (rd_pvld && rd_prdy) dut_pop++;
      check("credit", (dut_iss - dut_pop) <= 2, 1);

      if (e_push) begin
        dat[n_acc % M]   = wr_pd;
        acc_t[n_acc % M] = t;
        n_acc++;
      end
      if (e_iss) begin
        iss_t[n_iss % M] = t;
        n_iss++;
      end
      if (e_pop) n_pop++;
    end
    t++;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    for (int c = 0; c < 600 && n_pop < n_acc; c++) begin
      @(negedge clk);
      next_cycle();
    end
    check("drained", n_acc - n_pop, 0);
  endtask

  int k, p0;
  bit seen;

  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Single word latency
    wr_pvld = 1'b1; wr_pd = 64'hDEAD_BEEF_0000_0001; rd_prdy = 1'b1;
    @(negedge clk);
    check("t1_prdy", wr_prdy, 1);
    check("t1_cenb", ram_cenb, 0);
    check("t1_ab", ram_ab, 0);
    next_cycle();
    wr_pvld = 1'b0;
    @(negedge clk);
    check("t1_cena", ram_cena, 0);
    check("t1_aa", ram_aa, 0);
    check("t1_vld_c1", rd_pvld, 0);
    @(negedge clk);
    check("t1_vld_c2", rd_pvld, 0);
    @(negedge clk);
    check("t1_vld_c3", rd_pvld, 1);
    check("t1_pd", rd_pd, 64'hDEAD_BEEF_0000_0001);
    next_cycle();
    drain();

    // Fill to full capacity with the consumer stalled
    rd_prdy = 1'b0; wr_pvld = 1'b1; k = 0; wr_pd = 64'h1000;
    for (int c = 0; c < 600 && k < 258; c++) begin
      @(negedge clk);
      if (wr_prdy) k++;
      next_cycle();
      wr_pd = 64'h1000 + 64'(k);
    end
    check("t2_fill", k, 258);
    repeat (10) begin
      @(negedge clk);
      check("t2_hold", wr_prdy, 0);
      next_cycle();
    end
    @(negedge clk);
    check("t2_model_occ", n_acc - n_pop, 258);
    check("t2_vld", rd_pvld, 1);
    check("t2_head", rd_pd, 64'h1000);
    next_cycle();

    // Full FIFO streaming, wraps both addresses several times
    rd_prdy = 1'b1; p0 = n_pop;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (wr_prdy) k++;
      next_cycle();
      wr_pd = 64'h1000 + 64'(k);
    end
    check("t3_pops", n_pop - p0, 1000);
    drain();

    // Random traffic
    p0 = n_pop;
    for (int c = 0; c < 60000 && (n_pop - p0) < 10000; c++) begin
      wr_pvld = 1'($urandom_range(0, 1));
      rd_prdy = 1'($urandom_range(0, 1));
      wr_pd   = {$urandom, $urandom};
      @(negedge clk);
      next_cycle();
    end
    check("rand_items", (n_pop - p0) >= 10000, 1);
    drain();

    // Single entry with a toggling consumer
    for (int c = 0; c < 200; c++) begin
      rd_prdy = 1'(c % 2);
      wr_pvld = (n_acc == n_pop);
      wr_pd   = {$urandom, $urandom};
      @(negedge clk);
      next_cycle();
    end
    drain();

    // Reset in the middle of a burst
    rd_prdy = 1'b0; wr_pvld = 1'b1; k = 0;
    for (int c = 0; c < 300 && k < 100; c++) begin
      wr_pd = {$urandom, $urandom};
      @(negedge clk);
      if (wr_prdy) k++;
      next_cycle();
    end
    check("t5_fill", k, 100);
    rstn = 1'b0;
    #1;
    check("t5_now_vld", rd_pvld, 0);
    check("t5_now_cena", ram_cena, 1);
    check("t5_now_cenb", ram_cenb, 1);
    next_cycle();
    next_cycle();
    wr_pd = 64'hA5A5_0000_0000_0001;
    rstn  = 1'b1;
    @(negedge clk);
    check("t5_prdy", wr_prdy, 1);
    check("t5_ab", ram_ab, 0);
    next_cycle();
    wr_pvld = 1'b0; rd_prdy = 1'b1; seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (rd_pvld) begin
        seen = 1'b1;
        check("t5_first", rd_pd, 64'hA5A5_0000_0000_0001);
      end
      next_cycle();
    end
    check("t5_seen", seen, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
